// File: rtl/arbitro_mux4_rr.sv
// Round-robin arbiter sharing one 32-bit datapath resource among four
// requesters. Drives the select of the external 4:1 mux and a one-hot grant,
// holds each grant until the resource acknowledges or a timeout expires,
// and rotates priority so a continuously requesting unit cannot starve.
module arbitro_mux4_rr #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mem_ack,
    output logic [3:0] gnt,
    output logic [1:0] control,
    output logic       mem_valid,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_id
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_GRANT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Round-robin search starting at ptr_v. Returns {found, index}.
    // Offsets are scanned from farthest to nearest so the nearest set bit,
    // i.e. the highest-priority one, is the last to overwrite the result.
    function automatic logic [2:0] rr_pick(input logic [3:0] req_v,
                                           input logic [1:0] ptr_v);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_v + 2'(k);
            if (req_v[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Index to one-hot grant vector.
    function automatic logic [3:0] to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    logic [0:0]       state_r, state_s;
    logic [1:0]       ptr_r, ptr_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       gnt_r, gnt_s;
    logic [1:0]       control_r, control_s;
    logic             mem_valid_r, mem_valid_s;
    logic             busy_r, busy_s;
    logic             err_r, err_s;
    logic [1:0]       err_id_r, err_id_s;

    logic [2:0]       idle_pick_s;
    logic [1:0]       next_ptr_s;
    logic [2:0]       rearb_pick_s;
    logic             timeout_s;
    logic             release_s;

    // Fresh arbitration from IDLE uses the stored pointer and raw requests.
    assign idle_pick_s  = rr_pick(req, ptr_r);
    // On release, priority moves past the served requester, which is also
    // masked so it cannot be regranted while it still holds req high.
    assign next_ptr_s   = control_r + 2'd1;
    assign rearb_pick_s = rr_pick(req & ~gnt_r, next_ptr_s);
    assign timeout_s    = (cnt_r == CNT_LAST);
    assign release_s    = mem_ack | timeout_s;

    // Next-state and next-output computation for the IDLE/GRANT machine.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        cnt_s       = cnt_r;
        gnt_s       = gnt_r;
        control_s   = control_r;
        mem_valid_s = mem_valid_r;
        busy_s      = busy_r;
        err_s       = 1'b0;
        err_id_s    = err_id_r;
        case (state_r)
            ST_IDLE: begin
                // mem_ack is deliberately ignored here.
                cnt_s = {CNT_W{1'b0}};
                if (idle_pick_s[2]) begin
                    state_s     = ST_GRANT;
                    gnt_s       = to_onehot(idle_pick_s[1:0]);
                    control_s   = idle_pick_s[1:0];
                    mem_valid_s = 1'b1;
                    busy_s      = 1'b1;
                end else begin
                    state_s     = ST_IDLE;
                    gnt_s       = 4'b0000;
                    control_s   = 2'd0;
                    mem_valid_s = 1'b0;
                    busy_s      = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    ptr_s = next_ptr_s;
                    cnt_s = {CNT_W{1'b0}};
                    // An ack in the timeout cycle is a normal completion.
                    if (!mem_ack) begin
                        err_s    = 1'b1;
                        err_id_s = control_r;
                    end else begin
                        err_s    = 1'b0;
                        err_id_s = err_id_r;
                    end
                    if (rearb_pick_s[2]) begin
                        state_s     = ST_GRANT;
                        gnt_s       = to_onehot(rearb_pick_s[1:0]);
                        control_s   = rearb_pick_s[1:0];
                        mem_valid_s = 1'b1;
                        busy_s      = 1'b1;
                    end else begin
                        state_s     = ST_IDLE;
                        gnt_s       = 4'b0000;
                        control_s   = 2'd0;
                        mem_valid_s = 1'b0;
                        busy_s      = 1'b0;
                    end
                end else begin
                    // Grant held stable; request drops are ignored.
                    if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
            end
            default: begin
                state_s     = ST_IDLE;
                ptr_s       = 2'd0;
                cnt_s       = {CNT_W{1'b0}};
                gnt_s       = 4'b0000;
                control_s   = 2'd0;
                mem_valid_s = 1'b0;
                busy_s      = 1'b0;
                err_s       = 1'b0;
                err_id_s    = 2'd0;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 2'd0;
            cnt_r       <= {CNT_W{1'b0}};
            gnt_r       <= 4'b0000;
            control_r   <= 2'd0;
            mem_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            err_id_r    <= 2'd0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            cnt_r       <= cnt_s;
            gnt_r       <= gnt_s;
            control_r   <= control_s;
            mem_valid_r <= mem_valid_s;
            busy_r      <= busy_s;
            err_r       <= err_s;
            err_id_r    <= err_id_s;
        end
    end

    assign gnt       = gnt_r;
    assign control   = control_r;
    assign mem_valid = mem_valid_r;
    assign busy      = busy_r;
    assign err       = err_r;
    assign err_id    = err_id_r;

endmodule
